// File: rtl/pixie_pkg.sv
// Shared constants and FSM state type for the Pixie frame-buffer reader.
package pixie_pkg;

    localparam int BYTES_PER_LINE = 8;
    localparam int ACTIVE_LINES   = 128;
    localparam int FB_ADDR_W      = 10;
    localparam int H_ACTIVE       = 64;

    typedef enum logic {
        PRIME,
        RUN
    } state_t;

endpackage

// File: rtl/pixie_raster_timing.sv
// Pixie raster counters plus registered sync/blank decode.
// Outputs reflect the position at the enable that updated them.
module pixie_raster_timing
    import pixie_pkg::*;
#(
    parameter int H_TOTAL      = 112,
    parameter int H_SYNC_START = 80,
    parameter int H_SYNC_LEN   = 8,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_START = 200,
    parameter int V_SYNC_LEN   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank
);

    logic h_last;
    logic v_last;

    assign h_last = (hcount == 9'(H_TOTAL - 1));
    assign v_last = (vcount == 9'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hblank <= 1'b0;
            vblank <= 1'b0;
        end else if (adv) begin
            hcount <= h_last ? 9'd0 : hcount + 9'd1;
            if (h_last) begin
                vcount <= v_last ? 9'd0 : vcount + 9'd1;
            end
            hsync  <= (hcount >= 9'(H_SYNC_START))
                   && (hcount < 9'(H_SYNC_START + H_SYNC_LEN));
            vsync  <= (vcount >= 9'(V_SYNC_START))
                   && (vcount < 9'(V_SYNC_START + V_SYNC_LEN));
            hblank <= (hcount >= 9'(H_ACTIVE));
            vblank <= (vcount >= 9'(ACTIVE_LINES));
        end
    end

endmodule

// File: rtl/pixie_video_back_end.sv
// Pixie frame-buffer reader: prefetch, MSB-first serialiser, raster timing.
// Optional display gate input when PIXIE_DISP_GATE_EN is defined.
module pixie_video_back_end
    import pixie_pkg::*;
#(
    parameter int H_TOTAL      = 112,
    parameter int H_SYNC_START = 80,
    parameter int H_SYNC_LEN   = 8,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_START = 200,
    parameter int V_SYNC_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce_pix,
`ifdef PIXIE_DISP_GATE_EN
    input  logic                 disp_enable,
`endif
    output logic                 rd_en,
    output logic [FB_ADDR_W-1:0] rd_addr,
    input  logic [7:0]           rd_data,
    output logic                 pixel,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 hblank,
    output logic                 vblank
);

    state_t     state;
    state_t     state_nx;
    logic       prime_issue;
    logic       primed;
    logic       adv;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic [8:0] next_line;
    logic [2:0] byte_nx;
    logic       active;
    logic       byte_rd;
    logic       line_rd;
    logic       rd_pend;
    logic [7:0] hold;
    logic [7:0] shift;
    logic [7:0] load_val;
    logic [7:0] shift_nx;
    logic       en;
    logic       line_ok;

    assign adv = ce_pix && (state == RUN);

    pixie_raster_timing #(
        .H_TOTAL      (H_TOTAL),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_LEN   (H_SYNC_LEN),
        .V_TOTAL      (V_TOTAL),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_LEN   (V_SYNC_LEN)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .adv    (adv),
        .hcount (hcount),
        .vcount (vcount),
        .hsync  (hsync),
        .vsync  (vsync),
        .hblank (hblank),
        .vblank (vblank)
    );

`ifdef PIXIE_DISP_GATE_EN
    // Display resumes only at a line start so a partial line is never shown.
    logic disp_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_line <= 1'b1;
        end else if (adv) begin
            if (!disp_enable) begin
                disp_line <= 1'b0;
            end else if (hcount == 9'(H_TOTAL - 2)) begin
                disp_line <= 1'b1;
            end
        end
    end

    assign en      = disp_enable && disp_line;
    assign line_ok = disp_enable;
`else
    assign en      = 1'b1;
    assign line_ok = 1'b1;
`endif

    assign active    = (hcount < 9'(H_ACTIVE)) && (vcount < 9'(ACTIVE_LINES));
    assign next_line = (vcount == 9'(V_TOTAL - 1)) ? 9'd0 : vcount + 9'd1;
    assign byte_nx   = hcount[5:3] + 3'd1;
    assign byte_rd   = (hcount[2:0] == 3'd6)
                    && (hcount < 9'(H_ACTIVE - BYTES_PER_LINE))
                    && (vcount < 9'(ACTIVE_LINES));
    assign line_rd   = (hcount == 9'(H_TOTAL - 2))
                    && (next_line < 9'(ACTIVE_LINES));

    // A load can coincide with the capture edge of its own prefetch.
    assign load_val = rd_pend ? rd_data : hold;

    always_comb begin
        shift_nx = shift;
        if (active) begin
            shift_nx = (hcount[2:0] == 3'd0) ? load_val : shift << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= PRIME;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        prime_issue = 1'b0;
        case (state)
            PRIME: begin
                if (primed) state_nx = RUN;
                else        prime_issue = 1'b1;
            end
            RUN: state_nx = RUN;
            default: state_nx = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            primed  <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rd_pend <= 1'b0;
            hold    <= '0;
            shift   <= '0;
            pixel   <= 1'b0;
        end else begin
            rd_en   <= 1'b0;
            rd_pend <= rd_en;
            if (rd_pend) hold <= rd_data;
            if (prime_issue) begin
                primed  <= 1'b1;
                rd_en   <= 1'b1;
                rd_addr <= '0;
            end else if (adv) begin
                if (byte_rd && en) begin
                    rd_en   <= 1'b1;
                    rd_addr <= {vcount[6:0], byte_nx};
                end else if (line_rd && line_ok) begin
                    rd_en   <= 1'b1;
                    rd_addr <= {next_line[6:0], 3'd0};
                end
                shift <= shift_nx;
                pixel <= active && en && shift_nx[7];
            end
        end
    end

endmodule
